// File: rtl/env_vca_pkg.sv
// Shared synth definitions for the envelope-controlled amplifier: widths common
// with the envelope generator, FSM encoding and the envelope-to-gain mapping.
package env_vca_pkg;

    localparam int NBIT_DATA = 6;
    localparam int NBIT_SMP  = 12;

    localparam logic [NBIT_DATA:0] GAIN_UNITY = {1'b1, {NBIT_DATA{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // A full-scale envelope becomes exactly 2^NBIT_DATA so that it is a true unity gain.
    function automatic logic [NBIT_DATA:0] map_gain(input logic [NBIT_DATA-1:0] env,
                                                    input logic                 env_on);
        logic [NBIT_DATA:0] gain;
        if (!env_on) begin
            gain = {(NBIT_DATA+1){1'b0}};
        end else if (env == {NBIT_DATA{1'b1}}) begin
            gain = GAIN_UNITY;
        end else begin
            gain = {1'b0, env};
        end
        return gain;
    endfunction

endpackage

// File: rtl/env_vca_if.sv
// Sample stream bus between the oscillator/envelope side and the amplifier.
interface env_vca_if;
    import env_vca_pkg::*;

    logic                        smp_valid;
    logic signed [NBIT_SMP-1:0]  smp_in;
    logic        [NBIT_DATA-1:0] env;
    logic                        env_on;
    logic signed [NBIT_SMP-1:0]  smp_out;
    logic                        smp_out_valid;
    logic                        busy;
    logic                        ovr;

    modport master (
        output smp_valid, smp_in, env, env_on,
        input  smp_out, smp_out_valid, busy, ovr
    );

    modport slave (
        input  smp_valid, smp_in, env, env_on,
        output smp_out, smp_out_valid, busy, ovr
    );

endinterface

// File: rtl/env_vca_mul.sv
// Sequential signed x unsigned shift-add multiplier, one multiplier bit per cycle.
// done/result are valid in the cycle the last bit is being added, already scaled down.
module env_vca_mul #(
    parameter int NBIT_SMP  = 12,
    parameter int NBIT_DATA = 6
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic signed [NBIT_SMP-1:0]  a,
    input  logic        [NBIT_DATA:0]   b,
    output logic                        done,
    output logic signed [NBIT_SMP-1:0]  result
);

    localparam int ACC_W = NBIT_SMP + NBIT_DATA + 1;
    localparam int CNT_W = $clog2(NBIT_DATA + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBIT_DATA);

    logic                    run_q,    run_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic signed [ACC_W-1:0] acc_q,    acc_d;
    logic signed [ACC_W-1:0] mcand_q,  mcand_d;
    logic [NBIT_DATA:0]      mplier_q, mplier_d;
    logic signed [ACC_W-1:0] sum_s;

    assign done   = run_q && (cnt_q == LAST_BIT);
    // Taking the slice above the fraction bits is the floor of the arithmetic shift.
    assign result = sum_s[NBIT_DATA +: NBIT_SMP];

    // Next-state of the multiplier datapath.
    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sum_s    = acc_q + (mplier_q[0] ? mcand_q : {ACC_W{1'b0}});
        if (start) begin
            run_d    = 1'b1;
            cnt_d    = {CNT_W{1'b0}};
            acc_d    = {ACC_W{1'b0}};
            mcand_d  = {{(ACC_W-NBIT_SMP){a[NBIT_SMP-1]}}, a};
            mplier_d = b;
        end else if (run_q) begin
            acc_d    = sum_s;
            mcand_d  = mcand_q <<< 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done) begin
                run_d = 1'b0;
            end else begin
                run_d = 1'b1;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Multiplier datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {ACC_W{1'b0}};
            mcand_q  <= {ACC_W{1'b0}};
            mplier_q <= {(NBIT_DATA+1){1'b0}};
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/env_vca.sv
// Envelope-controlled amplifier: scales each strobed sample by the envelope gain
// with a fixed-latency sequential multiply and registered outputs.
module env_vca
    import env_vca_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    env_vca_if.slave  bus
);

    state_e                     state_q, state_d;
    logic                       accept_s;
    logic [NBIT_DATA:0]         gain_s;
    logic                       mul_done_s;
    logic signed [NBIT_SMP-1:0] mul_res_s;

    logic signed [NBIT_SMP-1:0] smp_out_q, smp_out_d;
    logic                       valid_q,   valid_d;
    logic                       busy_q,    busy_d;
    logic                       ovr_q,     ovr_d;

    // New samples are taken in IDLE and also in OUT so back-to-back streams lose no cycle.
    assign accept_s = bus.smp_valid && ((state_q == ST_IDLE) || (state_q == ST_OUT));
    assign gain_s   = map_gain(bus.env, bus.env_on);

    env_vca_mul #(
        .NBIT_SMP  (NBIT_SMP),
        .NBIT_DATA (NBIT_DATA)
    ) u_mul (
        .clk    (clk),
        .rstn   (rstn),
        .start  (accept_s),
        .a      (bus.smp_in),
        .b      (gain_s),
        .done   (mul_done_s),
        .result (mul_res_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.smp_valid) state_d = ST_MUL;
                else               state_d = ST_IDLE;
            end
            ST_MUL: begin
                if (mul_done_s) state_d = ST_OUT;
                else            state_d = ST_MUL;
            end
            ST_OUT: begin
                if (bus.smp_valid) state_d = ST_MUL;
                else               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic feeding the output registers.
    always_comb begin
        valid_d = mul_done_s;
        busy_d  = (state_d == ST_MUL);
        ovr_d   = bus.smp_valid && (state_q == ST_MUL);
        if (mul_done_s) begin
            smp_out_d = mul_res_s;
        end else begin
            smp_out_d = smp_out_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp_out_q <= {NBIT_SMP{1'b0}};
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            smp_out_q <= smp_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.smp_out       = smp_out_q;
    assign bus.smp_out_valid = valid_q;
    assign bus.busy          = busy_q;
    assign bus.ovr           = ovr_q;

endmodule
